// File: rtl/axi_lite_read_poller.sv
// axi_lite_read_poller
// AXI4-Lite read-only master. It issues single reads of a fixed register
// address, either on a one-shot request or periodically. The returned word is
// presented on rd_data together with a one-cycle rd_valid strobe. Non-OKAY
// responses pulse rd_err and bump a saturating error counter.
// Optional build macro AXI_POLL_CHANGE_ONLY_EN: rd_valid strobes only when a
// good read returns a value different from the held rd_data. The first good
// read after reset always strobes.
module axi_lite_read_poller #(
    parameter int                          C_M_AXI_ADDR_WIDTH = 32,
    parameter int                          C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] POLL_ADDR        = '0,
    parameter int                          POLL_PERIOD        = 1000
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    output logic                          M_AXI_ARVALID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    input  logic                          M_AXI_ARREADY,
    input  logic                          M_AXI_RVALID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    output logic                          M_AXI_RREADY,
    input  logic                          poll_en,
    input  logic                          rd_req,
    output logic                          busy,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rd_data,
    output logic                          rd_valid,
    output logic                          rd_err,
    output logic [7:0]                    err_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
    } state_t;

    localparam int                   TIMER_W      = (POLL_PERIOD > 2) ? $clog2(POLL_PERIOD) : 1;
    localparam logic [TIMER_W-1:0]   TIMER_RELOAD = TIMER_W'(POLL_PERIOD - 1);

    state_t               state;
    state_t               state_nxt;
    logic                 launch;
    logic                 r_done;
    logic                 resp_ok;
    logic                 expiry;
    logic                 good_strobe;
    logic                 pending;
    logic [TIMER_W-1:0]   timer;

    assign M_AXI_ARADDR = POLL_ADDR;
    assign expiry       = poll_en && (timer == '0);
    assign resp_ok      = (M_AXI_RRESP == 2'b00);

    // State register; the handshake outputs decode from it, so an async reset
    // drops ARVALID/RREADY without waiting for a clock edge.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded AXI/busy outputs.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the case
        // leaves a signal unassigned and no latch is inferred.
        state_nxt     = state;
        launch        = 1'b0;
        r_done        = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        busy          = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (rd_req || pending) begin
                    launch    = 1'b1;
                    state_nxt = S_ADDR;
                end
            end
            S_ADDR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) begin
                    r_done    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Poll timer: counts down while enabled, reloads on expiry or when disabled.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            timer <= TIMER_RELOAD;
        end else if (!poll_en || (timer == '0)) begin
            timer <= TIMER_RELOAD;
        end else begin
            timer <= timer - TIMER_W'(1);
        end
    end

    // Single pending-poll flag; a launch absorbs any expiry in the same cycle.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            pending <= 1'b0;
        end else if (launch) begin
            pending <= 1'b0;
        end else if (expiry) begin
            pending <= 1'b1;
        end
    end

`ifdef AXI_POLL_CHANGE_ONLY_EN
    logic first_done;

    // Remembers that a good read has landed since reset.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            first_done <= 1'b0;
        end else if (r_done && resp_ok) begin
            first_done <= 1'b1;
        end
    end

    assign good_strobe = !first_done || (M_AXI_RDATA != rd_data);
`else
    assign good_strobe = 1'b1;
`endif

    // Result capture, completion strobes and saturating error count.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            err_cnt  <= 8'd0;
        end else begin
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
            if (r_done) begin
                if (resp_ok) begin
                    rd_data  <= M_AXI_RDATA;
                    rd_valid <= good_strobe;
                end else begin
                    rd_err <= 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
            end
        end
    end

endmodule
